// File: rtl/mips_alu.sv
// mips_alu: registered 32-bit integer ALU for the MIPS32 execute stage.
// Operands are sampled on every rising clock edge and the selected result
// is captured in a register; zero is derived from that register so branch
// decisions and writeback both see the same settled value.
module mips_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       ALU_Ctrl,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  // Shift amount field width: only the low bits of operand A steer shifts.
  localparam int SHW = $clog2(WIDTH);

  // Operation encodings produced by ALU control decode.
  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b1001;
  localparam logic [3:0] OP_SRL  = 4'b1010;
  localparam logic [3:0] OP_SRA  = 4'b1011;
  localparam logic [3:0] OP_NOR  = 4'b1100;

  // Zero-extend a single compare bit to a full-width set-less-than result.
  function automatic logic [WIDTH-1:0] f_flag(input logic i_bit);
    logic [WIDTH-1:0] v;
    v        = {WIDTH{1'b0}};
    v[0]     = i_bit;
    return v;
  endfunction

  // Arithmetic right shift with sign-fill from the operand's top bit.
  function automatic logic [WIDTH-1:0] f_sra(input logic [WIDTH-1:0] i_val,
                                             input logic [SHW-1:0]   i_sh);
    return $unsigned($signed(i_val) >>> i_sh);
  endfunction

  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic             w_lt_signed;
  logic             w_lt_unsigned;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] r_result;

  // Shared datapath terms; carry out and overflow are intentionally dropped.
  assign w_shamt       = a[SHW-1:0];
  assign w_sum         = a + b;
  assign w_diff        = a - b;
  // True signed compare so SLT stays correct when a - b overflows.
  assign w_lt_signed   = ($signed(a) < $signed(b));
  assign w_lt_unsigned = (a < b);

  // Select the next result; undefined codes (including X in simulation)
  // fall to the default arm and yield zero rather than propagating X.
  always_comb begin
    w_next = {WIDTH{1'b0}};
    case (ALU_Ctrl)
      OP_AND:  w_next = a & b;
      OP_OR:   w_next = a | b;
      OP_ADD:  w_next = w_sum;
      OP_XOR:  w_next = a ^ b;
      OP_SUB:  w_next = w_diff;
      OP_SLT:  w_next = f_flag(w_lt_signed);
      OP_SLTU: w_next = f_flag(w_lt_unsigned);
      OP_SLL:  w_next = b << w_shamt;
      OP_SRL:  w_next = b >> w_shamt;
      OP_SRA:  w_next = f_sra(b, w_shamt);
      OP_NOR:  w_next = ~(a | b);
      default: w_next = {WIDTH{1'b0}};
    endcase
  end

  // Result register: cleared immediately by reset, otherwise loads every edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_result <= {WIDTH{1'b0}};
    end else begin
      r_result <= w_next;
    end
  end

  assign result = r_result;
  // Zero follows the register only, so it moves solely at an edge or reset.
  assign zero   = ~|r_result;

endmodule

// File: tb/tb_mips_alu.sv
// tb_mips_alu: table-driven directed test of mips_alu with hand-computed
// results, plus hand-written reset sequences.
module tb_mips_alu;

  logic        clk;
  logic        reset;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  ALU_Ctrl;
  logic [31:0] result;
  logic        zero;

  int n_vec;
  int n_err;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  mips_alu #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .a        (a),
    .b        (b),
    .ALU_Ctrl (ALU_Ctrl),
    .result   (result),
    .zero     (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic [31:0] exp);
    chk({nm, ".result"}, result, exp);
    chk({nm, ".zero"}, {31'd0, zero}, {31'd0, (exp == 32'd0)});
  endtask

  task automatic add_vec(input string nm, input logic [31:0] va, input logic [31:0] vb,
                         input logic [3:0] vc, input logic [31:0] ve);
    vec_t v;
    v.name = nm; v.a = va; v.b = vb; v.ctrl = vc; v.exp = ve;
    vecs.push_back(v);
  endtask

  initial begin
    logic [31:0] prev;
    n_vec = 0;
    n_err = 0;

    add_vec("add_4_8",      32'd4,          32'd8,          4'b0010, 32'h0000000C);
    add_vec("sub_4_8",      32'd4,          32'd8,          4'b0110, 32'hFFFFFFFC);
    add_vec("sub_8_8",      32'd8,          32'd8,          4'b0110, 32'h00000000);
    add_vec("or_4_8",       32'd4,          32'd8,          4'b0001, 32'h0000000C);
    add_vec("and_4_8",      32'd4,          32'd8,          4'b0000, 32'h00000000);
    add_vec("xor_4_8",      32'd4,          32'd8,          4'b0011, 32'h0000000C);
    add_vec("nor_4_8",      32'd4,          32'd8,          4'b1100, 32'hFFFFFFF3);
    add_vec("and_ff_f0",    32'hFFFF00FF,   32'h0F0F0F0F,   4'b0000, 32'h0F0F000F);
    add_vec("slt_4_8",      32'd4,          32'd8,          4'b0111, 32'h00000001);
    add_vec("slt_m1_1",     32'hFFFFFFFF,   32'd1,          4'b0111, 32'h00000001);
    add_vec("sltu_m1_1",    32'hFFFFFFFF,   32'd1,          4'b1000, 32'h00000000);
    add_vec("sltu_4_8",     32'd4,          32'd8,          4'b1000, 32'h00000001);
    add_vec("slt_min_max",  32'h80000000,   32'h7FFFFFFF,   4'b0111, 32'h00000001);
    add_vec("slt_max_min",  32'h7FFFFFFF,   32'h80000000,   4'b0111, 32'h00000000);
    add_vec("sll_4",        32'd4,          32'h80000010,   4'b1001, 32'h00000100);
    add_vec("srl_4",        32'd4,          32'h80000010,   4'b1010, 32'h08000001);
    add_vec("sra_4",        32'd4,          32'h80000010,   4'b1011, 32'hF8000001);
    add_vec("sll_24",       32'h24,         32'h80000010,   4'b1001, 32'h00000100);
    add_vec("srl_24",       32'h24,         32'h80000010,   4'b1010, 32'h08000001);
    add_vec("sra_24",       32'h24,         32'h80000010,   4'b1011, 32'hF8000001);
    add_vec("sra_pos",      32'd1,          32'h7FFFFFFE,   4'b1011, 32'h3FFFFFFF);
    add_vec("sub_0_1",      32'd0,          32'd1,          4'b0110, 32'hFFFFFFFF);
    add_vec("add_wrap",     32'hFFFFFFFF,   32'd1,          4'b0010, 32'h00000000);
    add_vec("add_big",      32'h7FFFFFFF,   32'd1,          4'b0010, 32'h80000000);
    add_vec("ill_0101",     32'hFFFFFFFF,   32'hFFFFFFFF,   4'b0101, 32'h00000000);
    add_vec("or_ones",      32'hFFFFFFFF,   32'hFFFFFFFF,   4'b0001, 32'hFFFFFFFF);
    add_vec("ill_0100",     32'hFFFFFFFF,   32'hFFFFFFFF,   4'b0100, 32'h00000000);
    add_vec("xor_a5",       32'hA5A5A5A5,   32'h0F0F0F0F,   4'b0011, 32'hAAAAAAAA);
    add_vec("ill_1101",     32'hFFFFFFFF,   32'hFFFFFFFF,   4'b1101, 32'h00000000);
    add_vec("nor_zero",     32'd0,          32'd0,          4'b1100, 32'hFFFFFFFF);
    add_vec("ill_1110",     32'hFFFFFFFF,   32'hFFFFFFFF,   4'b1110, 32'h00000000);
    add_vec("sub_big",      32'h12345678,   32'h02345677,   4'b0110, 32'h10000001);
    add_vec("ill_1111",     32'hFFFFFFFF,   32'hFFFFFFFF,   4'b1111, 32'h00000000);

    // Asynchronous reset: clear is visible before any clock edge.
    reset = 1'b1; a = 32'd4; b = 32'd8; ALU_Ctrl = 4'b0010;
    #2;
    chk_out("reset_async", 32'd0);
    @(posedge clk); #1;
    chk_out("reset_held", 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_out("reset_released", 32'd0);
    // First edge after release reflects inputs present at that edge.
    @(posedge clk); #1;
    chk_out("first_after_reset", 32'h0000000C);
    prev = 32'h0000000C;

    // Back-to-back vectors: new op every cycle, result one edge later.
    foreach (vecs[i]) begin
      @(negedge clk);
      a = vecs[i].a; b = vecs[i].b; ALU_Ctrl = vecs[i].ctrl;
      #1;
      chk({vecs[i].name, ".hold"}, result, prev);
      @(posedge clk); #1;
      chk_out(vecs[i].name, vecs[i].exp);
      prev = vecs[i].exp;
    end

    // Reset pulse between edges with a nonzero op pending.
    @(negedge clk);
    a = 32'd4; b = 32'd8; ALU_Ctrl = 4'b0001;
    @(posedge clk); #1;
    chk_out("pre_pulse", 32'h0000000C);
    #2;
    reset = 1'b1;
    #1;
    chk_out("mid_pulse_clear", 32'd0);
    @(posedge clk); #1;
    chk_out("pulse_over_edge", 32'd0);
    @(negedge clk);
    a = 32'h10; b = 32'h01; ALU_Ctrl = 4'b0110;
    reset = 1'b0;
    #1;
    chk_out("pulse_released", 32'd0);
    @(posedge clk); #1;
    chk_out("after_pulse", 32'h0000000F);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mips_alu.md
Name: mips_alu

Overview:
- Registered 32-bit integer ALU for the MIPS32 pipeline execute stage.
- Takes two operands and a 4-bit control code from ALU control decode.
- Produces a registered result and a zero flag, used for branch-equal decisions and writeback.
- One clock domain; asynchronous active-high reset.

Parameters:
- WIDTH, 32, operand/result width in bits; only 32 is required to be supported.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- a  input  WIDTH  operand A (rs value).
- b  input  WIDTH  operand B (rt value or sign-extended immediate).
- ALU_Ctrl  input  4  operation select.
- result  output  WIDTH  registered operation result.
- zero  output  1  high when result == 0.

Behaviour:
- Reset, asynchronous: while reset=1, result=0 and zero=1 immediately, regardless of clk.
- Latency: a, b and ALU_Ctrl are sampled on a rising clk edge with reset=0; result updates at that same edge (one-cycle latency, no handshake).
- A new operation is accepted every cycle.
- zero is combinational from the result register (zero = ~|result). It therefore changes only with result: at a clock edge or at reset.
- Operation encoding (ALU_Ctrl):
  - 0000: AND, a & b.
  - 0001: OR, a | b.
  - 0010: ADD, a + b modulo 2^32. Carry and overflow discarded; no exception, no overflow flag.
  - 0011: XOR, a ^ b.
  - 0110: SUB, a - b modulo 2^32 (two's complement).
  - 0111: SLT signed. result = 32'd1 if $signed(a) < $signed(b), else 0. Uses a true signed compare, not the sign of the subtraction, so it is correct on overflow.
  - 1000: SLTU unsigned. result = 1 if a < b unsigned, else 0.
  - 1001: SLL, b << a[4:0].
  - 1010: SRL, b >> a[4:0], logical.
  - 1011: SRA, b >>> a[4:0], arithmetic (sign-fill from b[31]).
  - 1100: NOR, ~(a | b).
- All other codes, including X/Z on ALU_Ctrl in simulation: result register loads 0, so zero=1. No X propagation from an undefined control.
- Shift amount: only a[4:0] is used; a[31:5] is ignored.
- Reset deasserted mid-stream: the first result after deassertion reflects the inputs at the first rising edge with reset low. Nothing is buffered from before or during reset.
- Reset asserted mid-operation: result goes to 0 immediately, overriding any pending edge.

Test Plan:
- Reset: reset=1, a=4, b=8 -> result=0, zero=1 asynchronously. Hold for one cycle, deassert, outputs stay 0/1 until the next edge.
- ADD/SUB: a=4, b=8, ALU_Ctrl=0010 -> result=12 (0x0000000C), zero=0 after one edge. Then ALU_Ctrl=0110 -> result=0xFFFFFFFC, zero=0. Also a=b=8 with SUB -> result=0, zero=1.
- Logic: a=4, b=8, AND (0000) -> result=0, zero=1. OR (0001) -> 12. XOR (0011) -> 12. NOR (1100) -> 0xFFFFFFF3.
- Compare: a=4, b=8, SLT (0111) -> 1. a=0xFFFFFFFF, b=1: SLT -> 1, SLTU (1000) -> 0. a=0x80000000, b=0x7FFFFFFF: SLT -> 1.
- Shifts: a=4, b=0x80000010: SLL -> 0x00000100, SRL -> 0x08000001, SRA -> 0xF8000001. a=0x24 (shamt 4) gives the same results as a=4.
- Edge cases:
  - ADD 0xFFFFFFFF + 1 -> 0, zero=1.
  - ALU_Ctrl=0101 or X -> result=0, zero=1.
  - Reset pulse mid-sequence, between clock edges -> immediate clear.
  - Back-to-back op changes every cycle -> each result appears exactly one edge later.
